// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tagged entries at the tail, collects out-of-order
// writebacks, retires from the head and flushes on a taken branch. Optional macro: ROB_WB_BYPASS_EN.

package team_params_pkg;
    parameter int REG_LEN       = 16;
    parameter int MEMI_SIZE_LOG = 8;
endpackage

module reorder_buffer
    import team_params_pkg::*;
#(
    parameter int ROB_SIZE_LOG = 3,
    parameter int RF_SIZE_LOG  = 2
) (
    input  logic                     clk,
    input  logic                     rst,

    // Allocation: an entry is taken when alloc_valid & alloc_ready on a rising edge.
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [MEMI_SIZE_LOG-1:0] alloc_pc,
    input  logic                     alloc_is_br,
    input  logic                     alloc_wen,
    input  logic [RF_SIZE_LOG-1:0]   alloc_rd,
    output logic [ROB_SIZE_LOG-1:0]  alloc_idx,

    input  logic                     wb_valid,
    input  logic [ROB_SIZE_LOG-1:0]  wb_idx,
    input  logic [REG_LEN-1:0]       wb_data,
    input  logic                     wb_taken,
    input  logic [MEMI_SIZE_LOG-1:0] wb_next_pc,

    output logic                     commit_valid,
    output logic                     commit_wen,
    output logic [RF_SIZE_LOG-1:0]   commit_rd,
    output logic [REG_LEN-1:0]       commit_data,

    output logic                     squash,
    output logic [MEMI_SIZE_LOG-1:0] squash_pc,

    output logic [ROB_SIZE_LOG:0]    count
);

    localparam int ROB_SIZE = 1 << ROB_SIZE_LOG;
    localparam logic [ROB_SIZE_LOG:0] FULL_COUNT = (ROB_SIZE_LOG + 1)'(ROB_SIZE);

    // Per-entry control bits
    logic [ROB_SIZE-1:0] valid_q, valid_d;
    logic [ROB_SIZE-1:0] done_q, done_d;
    logic [ROB_SIZE-1:0] is_br_q, is_br_d;
    logic [ROB_SIZE-1:0] wen_q, wen_d;
    logic [ROB_SIZE-1:0] taken_q, taken_d;

    // Per-entry payload
    logic [RF_SIZE_LOG-1:0]   rd_q      [ROB_SIZE];
    logic [RF_SIZE_LOG-1:0]   rd_d      [ROB_SIZE];
    logic [MEMI_SIZE_LOG-1:0] pc_q      [ROB_SIZE];
    logic [MEMI_SIZE_LOG-1:0] pc_d      [ROB_SIZE];
    logic [REG_LEN-1:0]       data_q    [ROB_SIZE];
    logic [REG_LEN-1:0]       data_d    [ROB_SIZE];
    logic [MEMI_SIZE_LOG-1:0] next_pc_q [ROB_SIZE];
    logic [MEMI_SIZE_LOG-1:0] next_pc_d [ROB_SIZE];

    logic [ROB_SIZE_LOG-1:0] head_q, head_d;
    logic [ROB_SIZE_LOG-1:0] tail_q, tail_d;
    logic [ROB_SIZE_LOG:0]   count_q, count_d;

    logic                     wb_hit;
    logic                     head_wb;
    logic                     head_taken;
    logic [REG_LEN-1:0]       head_data;
    logic [MEMI_SIZE_LOG-1:0] head_next_pc;
    logic                     commit_fire;
    logic                     squash_fire;
    logic                     alloc_fire;

    // Writebacks only land on live entries; stale tags fall on the floor.
    assign wb_hit = wb_valid & valid_q[wb_idx];

`ifdef ROB_WB_BYPASS_EN
    // A writeback to the head retires in the same cycle using the incoming result.
    assign head_wb = wb_hit & (wb_idx == head_q);
`else
    assign head_wb = 1'b0;
`endif

    assign head_taken   = head_wb ? wb_taken   : taken_q[head_q];
    assign head_data    = head_wb ? wb_data    : data_q[head_q];
    assign head_next_pc = head_wb ? wb_next_pc : next_pc_q[head_q];

    // Reset suppresses retirement so a reset mid-stream never writes the register file.
    assign commit_fire = ~rst & valid_q[head_q] & (done_q[head_q] | head_wb);
    assign squash_fire = commit_fire & is_br_q[head_q] & head_taken;

    assign alloc_ready = (count_q != FULL_COUNT) & ~squash_fire;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_idx   = tail_q;

    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        is_br_d   = is_br_q;
        wen_d     = wen_q;
        taken_d   = taken_q;
        rd_d      = rd_q;
        pc_d      = pc_q;
        data_d    = data_q;
        next_pc_d = next_pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (squash_fire) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_hit) begin
                done_d[wb_idx]    = 1'b1;
                data_d[wb_idx]    = wb_data;
                taken_d[wb_idx]   = wb_taken;
                next_pc_d[wb_idx] = wb_next_pc;
            end

            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end

            // Tail never aliases a retiring head: alloc is blocked when full.
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                is_br_d[tail_q] = alloc_is_br;
                wen_d[tail_q]   = alloc_wen;
                rd_d[tail_q]    = alloc_rd;
                pc_d[tail_q]    = alloc_pc;
                tail_d          = tail_q + 1'b1;
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk) begin
        is_br_q   <= is_br_d;
        wen_q     <= wen_d;
        taken_q   <= taken_d;
        rd_q      <= rd_d;
        pc_q      <= pc_d;
        data_q    <= data_d;
        next_pc_q <= next_pc_d;
    end

    assign commit_valid = commit_fire;
    assign commit_wen   = commit_fire & wen_q[head_q] & ~is_br_q[head_q];
    assign commit_rd    = commit_fire ? rd_q[head_q] : '0;
    assign commit_data  = commit_fire ? head_data : '0;
    assign squash       = squash_fire;
    assign squash_pc    = squash_fire ? head_next_pc : '0;
    assign count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, checked against an
// in-order queue model of the buffer contents.

module tb_reorder_buffer;

    localparam int RSL = 3;
    localparam int RFL = 2;
    localparam int RS  = 1 << RSL;
    localparam int RL  = team_params_pkg::REG_LEN;
    localparam int MSL = team_params_pkg::MEMI_SIZE_LOG;

`ifdef ROB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           alloc_valid;
    logic           alloc_ready;
    logic [MSL-1:0] alloc_pc;
    logic           alloc_is_br;
    logic           alloc_wen;
    logic [RFL-1:0] alloc_rd;
    logic [RSL-1:0] alloc_idx;
    logic           wb_valid;
    logic [RSL-1:0] wb_idx;
    logic [RL-1:0]  wb_data;
    logic           wb_taken;
    logic [MSL-1:0] wb_next_pc;
    logic           commit_valid;
    logic           commit_wen;
    logic [RFL-1:0] commit_rd;
    logic [RL-1:0]  commit_data;
    logic           squash;
    logic [MSL-1:0] squash_pc;
    logic [RSL:0]   count;

    reorder_buffer #(.ROB_SIZE_LOG(RSL), .RF_SIZE_LOG(RFL)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_is_br(alloc_is_br), .alloc_wen(alloc_wen), .alloc_rd(alloc_rd),
        .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .wb_taken(wb_taken),
        .wb_next_pc(wb_next_pc),
        .commit_valid(commit_valid), .commit_wen(commit_wen), .commit_rd(commit_rd),
        .commit_data(commit_data), .squash(squash), .squash_pc(squash_pc), .count(count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: live instructions oldest-first, each remembering its tag and result.
    typedef struct {
        int          tag;
        bit          is_br;
        bit          wen;
        int          rd;
        int          pc;
        bit          done;
        logic [RL-1:0] data;
        bit          taken;
        int          next_pc;
    } ent_t;

    ent_t mq[$];
    int   tail_m;
    int   errors;
    int   checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; alloc_valid = 1'b0; alloc_pc = '0; alloc_is_br = 1'b0; alloc_wen = 1'b0;
        alloc_rd = '0; wb_valid = 1'b0; wb_idx = '0; wb_data = '0; wb_taken = 1'b0;
        wb_next_pc = '0;
    endtask

    // One clock: drive, check all outputs against the model, advance the model on the edge.
    task automatic cycle(input bit r, input bit av, input bit br, input bit wen, input int rd,
                         input int pc, input bit wv, input int widx, input logic [RL-1:0] wd,
                         input bit wt, input int wnpc);
        int   n;
        int   hi;
        bit   head_bp;
        bit   ce;
        bit   se;
        bit   are;
        ent_t h;
        rst = r; alloc_valid = av; alloc_is_br = br; alloc_wen = wen;
        alloc_rd = RFL'(rd); alloc_pc = MSL'(pc);
        wb_valid = wv; wb_idx = RSL'(widx); wb_data = wd; wb_taken = wt; wb_next_pc = MSL'(wnpc);
        #1;
        n  = mq.size();
        hi = -1;
        for (int i = 0; i < n; i++) if (wv && mq[i].tag == widx) hi = i;
        head_bp = BYPASS && (n > 0) && wv && (mq[0].tag == widx);
        h = '{tag: 0, is_br: 0, wen: 0, rd: 0, pc: 0, done: 0, data: '0, taken: 0, next_pc: 0};
        if (n > 0) h = mq[0];
        if (head_bp) begin
            h.data = wd; h.taken = wt; h.next_pc = wnpc;
        end
        ce  = !r && (n > 0) && (h.done || head_bp);
        se  = ce && h.is_br && h.taken;
        are = (n != RS) && !se;
        chk("count", 64'(count), 64'(n));
        chk("alloc_ready", 64'(alloc_ready), 64'(are));
        chk("alloc_idx", 64'(alloc_idx), 64'(tail_m));
        chk("commit_valid", 64'(commit_valid), 64'(ce));
        chk("commit_wen", 64'(commit_wen), 64'(ce && h.wen && !h.is_br));
        chk("commit_rd", 64'(commit_rd), ce ? 64'(h.rd) : 64'd0);
        chk("commit_data", 64'(commit_data), ce ? 64'(h.data) : 64'd0);
        chk("squash", 64'(squash), 64'(se));
        chk("squash_pc", 64'(squash_pc), se ? 64'(h.next_pc) : 64'd0);
        @(posedge clk);
        if (r || se) begin
            mq.delete();
            tail_m = 0;
        end else begin
            if (hi >= 0) begin
                mq[hi].done = 1; mq[hi].data = wd; mq[hi].taken = wt; mq[hi].next_pc = wnpc;
            end
            if (ce) void'(mq.pop_front());
            if (av && are) begin
                mq.push_back('{tag: tail_m, is_br: br, wen: wen, rd: rd, pc: pc, done: 0,
                               data: '0, taken: 0, next_pc: 0});
                tail_m = (tail_m + 1) % RS;
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic alloc(input bit br, input bit wen, input int rd, input int pc);
        cycle(0, 1, br, wen, rd, pc, 0, 0, '0, 0, 0);
    endtask

    task automatic wb(input int idx, input logic [RL-1:0] d, input bit t, input int npc);
        cycle(0, 0, 0, 0, 0, 0, 1, idx, d, t, npc);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        tail_m = 0;
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_idle();
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_squash", 64'(squash), 64'd0);

        // Three plain ops retired in order despite out-of-order writebacks.
        alloc(0, 1, 1, 10);
        alloc(0, 1, 2, 11);
        alloc(0, 1, 3, 12);
        wb(2, RL'(16'h0333), 0, 0);
        wb(0, RL'(16'h0111), 0, 0);
        wb(1, RL'(16'h0222), 0, 0);
        idle(3);
        chk("drain_count", 64'(count), 64'd0);

        // Fill completely, then free one slot; the tail wraps back to 0.
        do_reset();
        for (int i = 0; i < RS; i++) alloc(0, 1, i % 4, 20 + i);
        chk("full_count", 64'(count), 64'(RS));
        chk("full_ready", 64'(alloc_ready), 64'd0);
        wb(0, RL'(16'h00aa), 0, 0);
        idle(1);
        chk("wrap_ready", 64'(alloc_ready), 64'd1);
        chk("wrap_idx", 64'(alloc_idx), 64'd0);
        alloc(0, 0, 2, 40);

        // Taken branch flushes the younger ops.
        do_reset();
        alloc(1, 1, 3, 4);
        alloc(0, 1, 1, 5);
        alloc(0, 1, 2, 6);
        wb(1, RL'(16'h0055), 0, 0);
        wb(2, RL'(16'h0066), 0, 0);
        wb(0, RL'(16'h0000), 1, 9);
        idle(2);
        chk("squash_count", 64'(count), 64'd0);
        chk("squash_idx", 64'(alloc_idx), 64'd0);

        // Writeback to the head: same-cycle commit only with the bypass.
        do_reset();
        alloc(0, 1, 1, 30);
        wb(0, RL'(16'h1234), 0, 0);
        chk("head_wb_next", 64'(commit_valid), BYPASS ? 64'd0 : 64'd1);
        idle(1);

        // Stale/unallocated writebacks change nothing.
        alloc(0, 1, 2, 31);
        wb(6, RL'(16'hdead), 0, 0);
        wb(0, RL'(16'hbeef), 1, 3);
        idle(1);
        chk("stale_commit", 64'(commit_valid), 64'd0);

        // Reset mid-stream with completed entries discards everything.
        do_reset();
        for (int i = 0; i < 5; i++) alloc(0, 1, i % 4, 50 + i);
        wb(1, RL'(16'h0001), 0, 0);
        wb(2, RL'(16'h0002), 0, 0);
        do_reset();
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_idx", 64'(alloc_idx), 64'd0);
        chk("midrst_commit", 64'(commit_valid), 64'd0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            bit r;
            bit wv;
            int widx;
            r  = ($urandom_range(0, 99) == 0);
            wv = ($urandom_range(0, 99) < 60);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                widx = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                widx = $urandom_range(0, RS - 1);
            cycle(r, ($urandom_range(0, 99) < 55), ($urandom_range(0, 4) == 0),
                  $urandom_range(0, 1), $urandom_range(0, (1 << RFL) - 1),
                  $urandom_range(0, (1 << MSL) - 1), wv, widx, RL'($urandom),
                  ($urandom_range(0, 1) == 1), $urandom_range(0, (1 << MSL) - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
